// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused every SHIFT cycle; the borrow is
// carried between cycles in br_q. The result and flags are registered and
// hold from DONE until the next accepted start.
//
// Handshake: start is sampled only while busy=0 (IDLE); the edge that sees
// start=1 in IDLE is the accept edge and latches a, b and bin. busy stays
// high from that edge until DONE ends. done pulses high for exactly one
// cycle (the DONE state) when diff/bout/ovf/zero become valid. start is
// ignored while busy=1.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             bout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;

  logic             bit_x;
  logic             bit_y;
  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] diff_d;

  // Full-subtractor cell on the current operand LSBs and the shifted diff.
  always_comb begin
    bit_x  = a_q[0];
    bit_y  = b_q[0];
    d_bit  = bit_x ^ bit_y ^ br_q;
    br_d   = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & br_q);
    diff_d = {d_bit, diff_q[WIDTH-1:1]};
  end

  // Control FSM plus datapath registers; all outputs come from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          diff_q <= diff_d;
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          br_q   <= br_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // Last bit: the cell's borrow-out and sum MSB give the flags.
            bout_q  <= br_d;
            ovf_q   <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
            zero_q  <= (diff_d == '0);
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign diff        = diff_q;
  assign bout        = bout_q;
  assign ovf         = ovf_q;
  assign zero        = zero_q;
  assign dbg_state_o = state_q;

endmodule
